vga_timing_gen: RTL and testbench

Generates 640x480@60 VGA raster timing for the pixel path. Presents pixel coordinates and a display-enable to `vga_draw` on the request side, then takes back the drawer's 16-bit RGB565 result. Outputs latency-matched, blanked RGB plus HSYNC/VSYNC to the DAC/pins. It sits between the pixel-clock domain root and the board VGA connector, with `vga_draw` in its loop.

---
 rtl/vga_timing_gen.sv | 152 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing with a latency-matched output stage around the vga_draw loop.
// Define VGA_TEST_PATTERN_EN to ignore iRGB and emit eight built-in vertical colour bars.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int DRAW_LAT = 1
) (
    input  logic        iVGA_CLK,
    input  logic        sys_rst,
    output logic [9:0]  ovga_x,
    output logic [9:0]  ovga_y,
    output logic        ovga_de,
    output logic        oframe_start,
    input  logic [15:0] iRGB,
    output logic [4:0]  oVGA_R,
    output logic [5:0]  oVGA_G,
    output logic [4:0]  oVGA_B,
    output logic        oVGA_HS,
    output logic        oVGA_VS,
    output logic        oVGA_BLANK_N
);

    localparam int H_T = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_T = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_LAST   = 10'(H_T - 1);
    localparam logic [9:0] V_LAST   = 10'(V_T - 1);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;
    logic       w_de;
    logic       w_hs_raw;
    logic       w_vs_raw;

    // Reset parks the counters on the last position so the first edge after release lands on (0,0).
    always_ff @(posedge iVGA_CLK or posedge sys_rst) begin
        if (sys_rst) begin
            r_h_cnt <= H_LAST;
            r_v_cnt <= V_LAST;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 10'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
        end
    end

    assign w_de         = (r_h_cnt < 10'(H_ACTIVE)) && (r_v_cnt < 10'(V_ACTIVE));
    assign ovga_de      = w_de;
    assign ovga_x       = w_de ? r_h_cnt : '0;
    assign ovga_y       = w_de ? r_v_cnt : '0;
    assign oframe_start = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign w_hs_raw     = !((r_h_cnt >= HS_START) && (r_h_cnt < HS_END));
    assign w_vs_raw     = !((r_v_cnt >= VS_START) && (r_v_cnt < VS_END));

`ifdef VGA_TEST_PATTERN_EN
    localparam int PW = 13;
    localparam logic [PW-1:0] PIPE_RST = {1'b0, 1'b1, 1'b1, 10'd0};
    logic [PW-1:0] w_pipe_in;
    assign w_pipe_in = {w_de, w_hs_raw, w_vs_raw, ovga_x};
`else
    localparam int PW = 3;
    localparam logic [PW-1:0] PIPE_RST = 3'b011;
    logic [PW-1:0] w_pipe_in;
    assign w_pipe_in = {w_de, w_hs_raw, w_vs_raw};
`endif

    logic [PW-1:0] w_pipe_out;

    generate
        if (DRAW_LAT == 0) begin : g_no_pipe
            assign w_pipe_out = w_pipe_in;
        end else begin : g_pipe
            logic [PW-1:0] r_pipe [DRAW_LAT];
            always_ff @(posedge iVGA_CLK or posedge sys_rst) begin
                if (sys_rst) begin
                    for (int i = 0; i < DRAW_LAT; i++) r_pipe[i] <= PIPE_RST;
                end else begin
                    r_pipe[0] <= w_pipe_in;
                    for (int i = 1; i < DRAW_LAT; i++) r_pipe[i] <= r_pipe[i-1];
                end
            end
            assign w_pipe_out = r_pipe[DRAW_LAT-1];
        end
    endgenerate

    logic        w_d_de;
    logic        w_d_hs;
    logic        w_d_vs;
    logic [15:0] w_pix;

    assign w_d_de = w_pipe_out[PW-1];
    assign w_d_hs = w_pipe_out[PW-2];
    assign w_d_vs = w_pipe_out[PW-3];

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;
    logic [9:0] w_d_x;
    logic [2:0] w_bar;
    assign w_d_x = w_pipe_out[9:0];

    always_comb begin
        w_bar = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (int'(w_d_x) >= i * BAR_W) w_bar = 3'(i);
        end
    end

    always_comb begin
        w_pix = 16'h0000;
        case (w_bar)
            3'd0: w_pix = 16'hFFFF;
            3'd1: w_pix = 16'hFFE0;
            3'd2: w_pix = 16'h07FF;
            3'd3: w_pix = 16'h07E0;
            3'd4: w_pix = 16'hF81F;
            3'd5: w_pix = 16'hF800;
            3'd6: w_pix = 16'h001F;
            default: w_pix = 16'h0000;
        endcase
    end
`else
    assign w_pix = iRGB;
`endif

    // Blanking is forced here so a drawer returning junk outside the active region never reaches the DAC.
    always_ff @(posedge iVGA_CLK or posedge sys_rst) begin
        if (sys_rst) begin
            oVGA_R       <= '0;
            oVGA_G       <= '0;
            oVGA_B       <= '0;
            oVGA_HS      <= 1'b1;
            oVGA_VS      <= 1'b1;
            oVGA_BLANK_N <= 1'b0;
        end else begin
            oVGA_BLANK_N <= w_d_de;
            oVGA_HS      <= w_d_hs;
            oVGA_VS      <= w_d_vs;
            {oVGA_R, oVGA_G, oVGA_B} <= w_d_de ? w_pix : 16'h0000;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one full-size instance plus three shrunken rasters covering DRAW_LAT 0/1/2/4,
// all checked against a time-indexed raster model.
module tb_vga_timing_gen;

    localparam int NI = 4;
    localparam int P_HA[NI]  = '{640, 16, 16, 16};
    localparam int P_HFP[NI] = '{16, 2, 2, 2};
    localparam int P_HS[NI]  = '{96, 4, 4, 4};
    localparam int P_HBP[NI] = '{48, 3, 3, 3};
    localparam int P_VA[NI]  = '{480, 6, 6, 6};
    localparam int P_VFP[NI] = '{10, 2, 2, 2};
    localparam int P_VS[NI]  = '{2, 2, 2, 2};
    localparam int P_VBP[NI] = '{33, 3, 3, 3};
    localparam int P_LAT[NI] = '{1, 0, 2, 4};

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        de;
        logic        fs;
        logic        hs;
        logic        vs;
        logic        bn;
        logic [15:0] rgb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] irgb [NI];
    logic [15:0] hist [NI][8];
    logic [9:0]  vx [NI];
    logic [9:0]  vy [NI];
    logic        vde [NI];
    logic        vfs [NI];
    logic        vhs [NI];
    logic        vvs [NI];
    logic        vbn [NI];
    logic [4:0]  vr [NI];
    logic [5:0]  vg [NI];
    logic [4:0]  vb [NI];

    int t;
    int rgb_mode;
    int errors;
    int checks;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        vga_timing_gen #(
            .H_ACTIVE(P_HA[g]), .H_FP(P_HFP[g]), .H_SYNC(P_HS[g]), .H_BP(P_HBP[g]),
            .V_ACTIVE(P_VA[g]), .V_FP(P_VFP[g]), .V_SYNC(P_VS[g]), .V_BP(P_VBP[g]),
            .DRAW_LAT(P_LAT[g])
        ) u_dut (
            .iVGA_CLK(clk),
            .sys_rst(rst),
            .ovga_x(vx[g]),
            .ovga_y(vy[g]),
            .ovga_de(vde[g]),
            .oframe_start(vfs[g]),
            .iRGB(irgb[g]),
            .oVGA_R(vr[g]),
            .oVGA_G(vg[g]),
            .oVGA_B(vb[g]),
            .oVGA_HS(vhs[g]),
            .oVGA_VS(vvs[g]),
            .oVGA_BLANK_N(vbn[g])
        );
    end

    function automatic int ht(int k);
        return P_HA[k] + P_HFP[k] + P_HS[k] + P_HBP[k];
    endfunction

    function automatic int vt(int k);
        return P_VA[k] + P_VFP[k] + P_VS[k] + P_VBP[k];
    endfunction

    function automatic logic [15:0] bar_colour(int idx);
        case (idx)
            0: return 16'hFFFF;
            1: return 16'hFFE0;
            2: return 16'h07FF;
            3: return 16'h07E0;
            4: return 16'hF81F;
            5: return 16'hF800;
            6: return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    // tt = edges since reset release (0 is the first edge, -1 while in reset).
    function automatic exp_t model(int k, int tt);
        exp_t e;
        int   h, v, td, hd, vd;
        logic ded;
        e    = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        if (tt >= 0) begin
            h    = tt % ht(k);
            v    = (tt / ht(k)) % vt(k);
            e.de = (h < P_HA[k]) && (v < P_VA[k]);
            e.x  = e.de ? 10'(h) : 10'd0;
            e.y  = e.de ? 10'(v) : 10'd0;
            e.fs = (h == 0) && (v == 0);
        end
        td = tt - P_LAT[k] - 1;
        if (td >= 0) begin
            hd   = td % ht(k);
            vd   = (td / ht(k)) % vt(k);
            ded  = (hd < P_HA[k]) && (vd < P_VA[k]);
            e.bn = ded;
            e.hs = !((hd >= P_HA[k] + P_HFP[k]) && (hd < P_HA[k] + P_HFP[k] + P_HS[k]));
            e.vs = !((vd >= P_VA[k] + P_VFP[k]) && (vd < P_VA[k] + P_VFP[k] + P_VS[k]));
`ifdef VGA_TEST_PATTERN_EN
            e.rgb = ded ? bar_colour(hd / (P_HA[k] / 8)) : 16'h0000;
`else
            e.rgb = ded ? hist[k][(tt - 1) % 8] : 16'h0000;
`endif
        end
        return e;
    endfunction

    function automatic logic sig(int k, int j);
        case (j)
            0: return !vhs[k];
            1: return !vvs[k];
            2: return vde[k];
            default: return vbn[k];
        endcase
    endfunction

    // Advance one clock, land 1 time unit after the edge, then drive iRGB for the coming cycle.
    task automatic tick();
        logic [15:0] v;
        @(posedge clk);
        #1;
        if (!rst) t++;
        for (int k = 0; k < NI; k++) begin
            case (rgb_mode)
                0: v = 16'($urandom);
                1: v = 16'hFFFF;
                default: v = (t == 3 * ht(k) + 5 + P_LAT[k]) ? 16'hF800 : 16'h0000;
            endcase
            irgb[k] = v;
            if (t >= 0) hist[k][t % 8] = v;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        t   = -1;
        repeat (10) tick();
        for (int k = 0; k < NI; k++) begin
            checks++;
            if ({vhs[k], vvs[k], vbn[k]} !== 3'b110) begin
                errors++;
                $display("FAIL reset_syncs k=%0d got=%b exp=110", k, {vhs[k], vvs[k], vbn[k]});
            end
            checks++;
            if ({vr[k], vg[k], vb[k]} !== 16'h0000) begin
                errors++;
                $display("FAIL reset_rgb k=%0d got=%h exp=0000", k, {vr[k], vg[k], vb[k]});
            end
            checks++;
            if ({vx[k], vy[k], vde[k], vfs[k]} !== 22'd0) begin
                errors++;
                $display("FAIL reset_request k=%0d got=%h exp=0", k, {vx[k], vy[k], vde[k], vfs[k]});
            end
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        for (int k = 0; k < NI; k++) begin
            checks++;
            if ({vx[k], vy[k], vde[k], vfs[k]} !== {10'd0, 10'd0, 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL first_edge k=%0d got x=%0d y=%0d de=%b fs=%b exp x=0 y=0 de=1 fs=1",
                         k, vx[k], vy[k], vde[k], vfs[k]);
            end
        end
    endtask

    task automatic test_latency();
`ifndef VGA_TEST_PATTERN_EN
        int   hits [NI];
        int   hit_t [NI];
        exp_t e;
        rgb_mode = 2;
        for (int k = 0; k < NI; k++) begin
            hits[k]  = 0;
            hit_t[k] = -1;
        end
        while (t < 3 * ht(0) + 20) begin
            tick();
            for (int k = 0; k < NI; k++) begin
                e = model(k, t);
                if ({vr[k], vg[k], vb[k]} === 16'hF800) begin
                    hits[k]++;
                    hit_t[k] = t;
                end
                checks++;
                if ({vr[k], vg[k], vb[k]} !== e.rgb) begin
                    errors++;
                    $display("FAIL latency_rgb k=%0d t=%0d got=%h exp=%h", k, t, {vr[k], vg[k], vb[k]}, e.rgb);
                end
            end
        end
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (hits[k] !== 1 || hit_t[k] !== 3 * ht(k) + 5 + P_LAT[k] + 1) begin
                errors++;
                $display("FAIL latency_pulse k=%0d got hits=%0d at t=%0d exp hits=1 at t=%0d",
                         k, hits[k], hit_t[k], 3 * ht(k) + 5 + P_LAT[k] + 1);
            end
        end
`endif
    endtask

    task automatic test_random_pixels(input int n);
        exp_t e;
        rgb_mode = 0;
        repeat (n) begin
            tick();
            for (int k = 0; k < NI; k++) begin
                e = model(k, t);
                checks++;
                if ({vx[k], vy[k], vde[k], vfs[k]} !== {e.x, e.y, e.de, e.fs}) begin
                    errors++;
                    $display("FAIL request k=%0d t=%0d got x=%0d y=%0d de=%b fs=%b exp x=%0d y=%0d de=%b fs=%b",
                             k, t, vx[k], vy[k], vde[k], vfs[k], e.x, e.y, e.de, e.fs);
                end
                checks++;
                if ({vhs[k], vvs[k], vbn[k], vr[k], vg[k], vb[k]} !== {e.hs, e.vs, e.bn, e.rgb}) begin
                    errors++;
                    $display("FAIL output k=%0d t=%0d got hs=%b vs=%b bn=%b rgb=%h exp hs=%b vs=%b bn=%b rgb=%h",
                             k, t, vhs[k], vvs[k], vbn[k], {vr[k], vg[k], vb[k]}, e.hs, e.vs, e.bn, e.rgb);
                end
            end
        end
    endtask

    task automatic test_line_frame_timing(input int n);
        int   run [NI][4];
        int   last [NI][4];
        logic prev [NI][4];
        int   last_fs [NI];
        int   len, per;
        logic cur;
        rgb_mode = 0;
        for (int k = 0; k < NI; k++) begin
            last_fs[k] = -1;
            for (int j = 0; j < 4; j++) begin
                run[k][j]  = -1;
                last[k][j] = -1;
                prev[k][j] = sig(k, j);
            end
        end
        repeat (n) begin
            tick();
            for (int k = 0; k < NI; k++) begin
                for (int j = 0; j < 4; j++) begin
                    len = (j == 0) ? P_HS[k] : (j == 1) ? P_VS[k] * ht(k) : P_HA[k];
                    per = (j == 0) ? ht(k) : (j == 1) ? ht(k) * vt(k) : 0;
                    cur = sig(k, j);
                    if (cur && !prev[k][j]) begin
                        if (per > 0 && last[k][j] >= 0) begin
                            checks++;
                            if (t - last[k][j] !== per) begin
                                errors++;
                                $display("FAIL period k=%0d sig=%0d got=%0d exp=%0d", k, j, t - last[k][j], per);
                            end
                        end
                        last[k][j] = t;
                        run[k][j]  = 1;
                    end else if (cur && run[k][j] >= 0) begin
                        run[k][j]++;
                    end else if (!cur && prev[k][j] && run[k][j] >= 0) begin
                        checks++;
                        if (run[k][j] !== len) begin
                            errors++;
                            $display("FAIL width k=%0d sig=%0d got=%0d exp=%0d", k, j, run[k][j], len);
                        end
                        run[k][j] = -1;
                    end
                    prev[k][j] = cur;
                end
                if (vfs[k]) begin
                    if (last_fs[k] >= 0) begin
                        checks++;
                        if (t - last_fs[k] !== ht(k) * vt(k)) begin
                            errors++;
                            $display("FAIL frame_period k=%0d got=%0d exp=%0d", k, t - last_fs[k], ht(k) * vt(k));
                        end
                    end
                    last_fs[k] = t;
                end
            end
        end
    endtask

    task automatic test_blanking(input int n);
        exp_t e;
        rgb_mode = 1;
        repeat (n) begin
            tick();
            for (int k = 0; k < NI; k++) begin
                e = model(k, t);
                checks++;
                if (vbn[k] !== e.bn) begin
                    errors++;
                    $display("FAIL blank_n k=%0d t=%0d got=%b exp=%b", k, t, vbn[k], e.bn);
                end
                checks++;
                if ({vr[k], vg[k], vb[k]} !== e.rgb) begin
                    errors++;
                    $display("FAIL blanked_rgb k=%0d t=%0d got=%h exp=%h", k, t, {vr[k], vg[k], vb[k]}, e.rgb);
                end
            end
        end
    endtask

    task automatic test_mid_frame_reset();
        int   guard;
        int   fs_n [NI];
        int   fs_t [NI][2];
        exp_t e;
        rgb_mode = 0;
        guard    = 0;
        do begin
            tick();
            guard++;
        end while ((t % (ht(1) * vt(1))) != 3 * ht(1) + 10 && guard < 1000);
        checks++;
        if (guard >= 1000) begin
            errors++;
            $display("FAIL mid_reset_position got t=%0d exp position v=3 h=10", t);
        end
        rst = 1'b1;
        #1;
        for (int k = 0; k < NI; k++) begin
            checks++;
            if ({vx[k], vy[k], vde[k], vfs[k]} !== 22'd0) begin
                errors++;
                $display("FAIL async_reset_request k=%0d got=%h exp=0", k, {vx[k], vy[k], vde[k], vfs[k]});
            end
            checks++;
            if ({vhs[k], vvs[k], vbn[k], vr[k], vg[k], vb[k]} !== {3'b110, 16'h0000}) begin
                errors++;
                $display("FAIL async_reset_output k=%0d got=%h exp=%h", k,
                         {vhs[k], vvs[k], vbn[k], vr[k], vg[k], vb[k]}, {3'b110, 16'h0000});
            end
        end
        t = -1;
        repeat (3) tick();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < NI; k++) begin
            fs_n[k]    = 0;
            fs_t[k][0] = -1;
            fs_t[k][1] = -1;
        end
        repeat (700) begin
            tick();
            for (int k = 0; k < NI; k++) begin
                e = model(k, t);
                if (vfs[k] && fs_n[k] < 2) begin
                    fs_t[k][fs_n[k]] = t;
                    fs_n[k]++;
                end
                checks++;
                if ({vx[k], vy[k], vde[k], vfs[k], vhs[k], vvs[k], vbn[k], vr[k], vg[k], vb[k]} !== e) begin
                    errors++;
                    $display("FAIL restart k=%0d t=%0d got=%h exp=%h", k, t,
                             {vx[k], vy[k], vde[k], vfs[k], vhs[k], vvs[k], vbn[k], vr[k], vg[k], vb[k]}, e);
                end
            end
        end
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (fs_t[k][0] !== 0) begin
                errors++;
                $display("FAIL restart_first_frame k=%0d got t=%0d exp t=0", k, fs_t[k][0]);
            end
        end
        for (int k = 1; k < NI; k++) begin
            checks++;
            if (fs_t[k][1] !== ht(k) * vt(k)) begin
                errors++;
                $display("FAIL restart_next_frame k=%0d got t=%0d exp t=%0d", k, fs_t[k][1], ht(k) * vt(k));
            end
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        t        = -1;
        rgb_mode = 2;
        rst      = 1'b1;
        for (int k = 0; k < NI; k++) irgb[k] = 16'h0000;
        test_reset();
        test_latency();
        test_random_pixels(1200);
        test_line_frame_timing(1700);
        test_blanking(900);
        test_mid_frame_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog t=%0d", t);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
